// File: rtl/ctrl_pkg.sv
// Shared types for the control-CPU SRAM path: sequencer states, requester IDs
// and the board SRAM word-address width.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    ACK,
    GAP
  } state_e;

  typedef enum logic {
    ICPU = 1'b0,
    DCPU = 1'b1
  } req_id_e;

  localparam int SRAM_AW = 18;

endpackage

// File: rtl/ctrl_sram_arb.sv
// Shares the 16-bit async SRAM between the CPU instruction and data ports.
// Each 32-bit access is split into a high and a low phase. Define CTRL_SRAM_ARB_RR_EN for round-robin arbitration.
module ctrl_sram_arb
  import ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               icpu_cs,
  input  logic [31:0]        icpu_adr,
  output logic [31:0]        icpu_dat_r,
  output logic               icpu_ack,
  input  logic               dcpu_cs,
  input  logic               dcpu_we,
  input  logic [3:0]         dcpu_sel,
  input  logic [31:0]        dcpu_adr,
  input  logic [31:0]        dcpu_dat_w,
  output logic [31:0]        dcpu_dat_r,
  output logic               dcpu_ack,
  output logic [SRAM_AW-1:0] sram_adr,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n,
  output logic [15:0]        sram_dat_w,
  input  logic [15:0]        sram_dat_r
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

  state_e               state, state_nx;
  logic   [3:0]         cnt;
  req_id_e              gnt, win;
  logic   [SRAM_AW-2:0] adr_q;
  logic                 we_q;
  logic   [3:0]         sel_q;
  logic   [31:0]        dat_w_q;
  logic   [15:0]        rd_hi;
  logic                 phase_last;
  logic                 any_cs;
  logic   [1:0]         half_sel;
  logic   [15:0]        half_dat;
  logic                 unused_adr;

  assign unused_adr = ^{icpu_adr[31:19], icpu_adr[1:0], dcpu_adr[31:19], dcpu_adr[1:0]};

  assign any_cs     = icpu_cs | dcpu_cs;
  assign phase_last = (cnt == LAST_CNT);

`ifdef CTRL_SRAM_ARB_RR_EN
  req_id_e last_gnt;

  always_comb begin
    if (icpu_cs && dcpu_cs) win = (last_gnt == DCPU) ? ICPU : DCPU;
    else                    win = dcpu_cs ? DCPU : ICPU;
  end

  always_ff @(posedge clk) begin
    if (rst)                          last_gnt <= DCPU;
    else if (state == IDLE && any_cs) last_gnt <= win;
  end
`else
  assign win = dcpu_cs ? DCPU : ICPU;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_cs) state_nx = HI;
      HI:      if (phase_last) state_nx = LO;
      LO:      if (phase_last) state_nx = ACK;
      ACK:     state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt        <= ICPU;
      adr_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      dat_w_q    <= '0;
      rd_hi      <= '0;
      icpu_dat_r <= '0;
      dcpu_dat_r <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state)              cnt <= '0;
      else if (state == HI || state == LO) cnt <= cnt + 4'd1;

      if (state == IDLE && any_cs) begin
        gnt <= win;
        if (win == DCPU) begin
          adr_q   <= dcpu_adr[18:2];
          we_q    <= dcpu_we;
          sel_q   <= dcpu_sel;
          dat_w_q <= dcpu_dat_w;
        end else begin
          adr_q   <= icpu_adr[18:2];
          we_q    <= 1'b0;
          sel_q   <= 4'b1111;
          dat_w_q <= '0;
        end
      end

      if (state == HI && phase_last && !we_q) rd_hi <= sram_dat_r;
      if (state == LO && phase_last && !we_q) begin
        if (gnt == DCPU) dcpu_dat_r <= {rd_hi, sram_dat_r};
        else             icpu_dat_r <= {rd_hi, sram_dat_r};
      end
    end
  end

  assign icpu_ack = (state == ACK) && (gnt == ICPU);
  assign dcpu_ack = (state == ACK) && (gnt == DCPU);

  assign half_sel = (state == LO) ? sel_q[1:0]    : sel_q[3:2];
  assign half_dat = (state == LO) ? dat_w_q[15:0] : dat_w_q[31:16];

  // Strobes decode straight from the registered state, so a reset edge idles them immediately.
  always_comb begin
    sram_adr   = '0;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_ub_n  = 1'b1;
    sram_lb_n  = 1'b1;
    sram_dat_w = '0;
    if (state == HI || state == LO) begin
      sram_adr  = {adr_q, (state == LO)};
      sram_ce_n = 1'b0;
      if (we_q) begin
        sram_ub_n  = ~half_sel[1];
        sram_lb_n  = ~half_sel[0];
        // Last cycle of the phase releases we_n to hold address and data.
        sram_we_n  = ~((|half_sel) && (cnt < LAST_CNT));
        sram_dat_w = half_dat;
      end else begin
        sram_oe_n = 1'b0;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
      end
    end
  end

endmodule
